// File: rtl/gjy_uart_rx_fifo_if.sv
// gjy_uart_rx_fifo_if: byte/handshake bundle between UART receiver, register block and the rx FIFO
interface gjy_uart_rx_fifo_if #(
  parameter int AW = 4
);
  logic          rx_ok;
  logic [7:0]    rx_data;
  logic          pop;
  logic          flush;
  logic          ovr_clr;
  logic [AW:0]   thresh;
  logic          irq_en;
  logic [7:0]    rd_data;
  logic          empty;
  logic          full;
  logic [AW:0]   count;
  logic          ovr;
  logic          irq;
  modport master (
    output rx_ok, rx_data, pop, flush, ovr_clr, thresh, irq_en,
    input  rd_data, empty, full, count, ovr, irq
  );
  modport slave (
    input  rx_ok, rx_data, pop, flush, ovr_clr, thresh, irq_en,
    output rd_data, empty, full, count, ovr, irq
  );
endinterface

// File: rtl/gjy_uart_rx_fifo.sv
// gjy_uart_rx_fifo: edge-triggered rx byte FIFO with sticky overrun; registered irq when UART_RX_FIFO_IRQ_EN is defined
module gjy_uart_rx_fifo #(
  parameter int AW    = 4,
  parameter int DEPTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  gjy_uart_rx_fifo_if.slave    rx_if
);
  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          ovr_q, ovr_d, rx_ok_q;
  logic          push, pop_ok, wr_en, empty, full;
  always_comb begin
    push     = rx_if.rx_ok & ~rx_ok_q;
    empty    = count_q == '0;
    full     = count_q == (AW+1)'(DEPTH);
    pop_ok   = rx_if.pop & ~empty;
    wr_en    = push & (~full | pop_ok) & ~rx_if.flush;
    wr_ptr_d = rx_if.flush ? '0 : wr_ptr_q + AW'(wr_en);
    rd_ptr_d = rx_if.flush ? '0 : rd_ptr_q + AW'(pop_ok);
    count_d  = rx_if.flush ? '0 : count_q + (AW+1)'(wr_en) - (AW+1)'(pop_ok);
    ovr_d    = rx_if.flush ? 1'b0 : (push & full & ~pop_ok) ? 1'b1 : rx_if.ovr_clr ? 1'b0 : ovr_q;
  end
  // rx_ok_q resets high so an rx_ok already high out of reset is not seen as a new byte
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovr_q    <= 1'b0;
      rx_ok_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovr_q    <= ovr_d;
      rx_ok_q  <= rx_if.rx_ok;
    end
  end
  always_ff @(posedge clk) begin
    if (rst_n && wr_en) mem_q[wr_ptr_q] <= rx_if.rx_data;
  end
  assign rx_if.rd_data = empty ? 8'h00 : mem_q[rd_ptr_q];
  assign rx_if.empty   = empty;
  assign rx_if.full    = full;
  assign rx_if.count   = count_q;
  assign rx_if.ovr     = ovr_q;
`ifdef UART_RX_FIFO_IRQ_EN
  logic irq_q, irq_d;
  always_comb irq_d = rx_if.irq_en & (((rx_if.thresh != '0) & (count_d >= rx_if.thresh)) | ovr_d);
  always_ff @(posedge clk) begin
    irq_q <= rst_n ? irq_d : 1'b0;
  end
  assign rx_if.irq = irq_q;
`else
  assign rx_if.irq = 1'b0;
`endif
endmodule

// File: tb/tb_gjy_uart_rx_fifo.sv
// tb_gjy_uart_rx_fifo: randomized + directed scoreboard bench for gjy_uart_rx_fifo
module tb_gjy_uart_rx_fifo;
  localparam int AW = 4, DEPTH = 16;
  logic clk = 1'b0;
  logic rst_n;
  gjy_uart_rx_fifo_if #(.AW(AW)) bus ();
  gjy_uart_rx_fifo #(.AW(AW), .DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .rx_if(bus));
  always #5 clk = ~clk;
  int checks = 0, failures = 0;
  byte unsigned sb_q[$];
  int m_cnt = 0;
  bit m_ovr = 0, m_irq = 0, m_prev = 1, go = 0;
  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // monitor: compares state every cycle and pops the scoreboard on each effective read
  always @(negedge clk) if (go) begin
    chk("count", int'(bus.count), m_cnt);
    chk("empty", int'(bus.empty), int'(m_cnt == 0));
    chk("full", int'(bus.full), int'(m_cnt == DEPTH));
    chk("ovr", int'(bus.ovr), int'(m_ovr));
    chk("irq", int'(bus.irq), int'(m_irq));
    if (m_cnt == 0) chk("rd_data_empty", int'(bus.rd_data), 0);
    if (bus.pop && !bus.empty) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL pop_underflow: got data %0h expected no data at %0t", bus.rd_data, $time);
      end else chk("rd_data", int'(bus.rd_data), int'(sb_q.pop_front()));
    end
  end
  task automatic step(bit r, bit rx, byte unsigned d, bit p, bit f, bit c);
    bit push, pok, acc;
    rst_n = r; bus.rx_ok = rx; bus.rx_data = d; bus.pop = p; bus.flush = f; bus.ovr_clr = c;
    @(posedge clk);
    #1;
    if (!r) begin
      m_cnt = 0; m_ovr = 0; m_prev = 1; m_irq = 0;
      sb_q.delete();
    end else begin
      push = rx && !m_prev;
      m_prev = rx;
      if (f) begin
        m_cnt = 0; m_ovr = 0;
        sb_q.delete();
      end else begin
        pok = p && m_cnt > 0;
        acc = push && (m_cnt < DEPTH || pok);
        if (acc) sb_q.push_back(d);
        m_cnt = m_cnt + int'(acc) - int'(pok);
        m_ovr = (push && !acc) ? 1'b1 : c ? 1'b0 : m_ovr;
      end
`ifdef UART_RX_FIFO_IRQ_EN
      m_irq = bus.irq_en && ((bus.thresh != 0 && m_cnt >= int'(bus.thresh)) || m_ovr);
`else
      m_irq = 0;
`endif
    end
    go = 1;
  endtask
  task automatic push_byte(byte unsigned d);
    step(1, 1, d, 0, 0, 0);
    step(1, 0, 8'h00, 0, 0, 0);
  endtask
  task automatic pop_byte();
    step(1, 0, 8'h00, 1, 0, 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int pp;
    bus.thresh = 5'd4; bus.irq_en = 1'b1;
    step(0, 1, 8'h00, 0, 0, 0);
    step(0, 1, 8'h00, 0, 0, 0);
    step(1, 1, 8'h11, 0, 0, 0);
    step(1, 0, 8'h00, 0, 0, 0);
    push_byte(8'h41); push_byte(8'h42); push_byte(8'h43);
    repeat (3) pop_byte();
    step(1, 0, 8'h00, 0, 0, 0);
    repeat (10) step(1, 1, 8'h55, 0, 0, 0);
    step(1, 0, 8'h00, 0, 0, 0);
    pop_byte();
    for (int i = 0; i < 17; i++) push_byte(8'(i));
    step(1, 0, 8'h00, 0, 0, 1);
    repeat (16) pop_byte();
    for (int i = 0; i < 16; i++) push_byte(8'(i + 16));
    step(1, 1, 8'hAA, 1, 0, 0);
    step(1, 0, 8'h00, 0, 0, 0);
    repeat (16) pop_byte();
    step(1, 1, 8'h77, 1, 0, 0);
    step(1, 0, 8'h00, 1, 0, 0);
    for (int i = 0; i < 5; i++) push_byte(8'(i + 8'h60));
    step(1, 1, 8'h99, 0, 1, 0);
    step(1, 0, 8'h00, 0, 0, 0);
    for (int i = 0; i < 3; i++) push_byte(8'(i + 8'h70));
    step(0, 1, 8'h88, 1, 0, 0);
    step(1, 0, 8'h00, 0, 0, 0);
    bus.thresh = '0;
    for (int i = 0; i < 17; i++) push_byte(8'(i + 8'h80));
    step(1, 0, 8'h00, 0, 0, 1);
    step(1, 1, 8'h5A, 0, 0, 1);
    step(1, 0, 8'h00, 0, 1, 0);
    for (int k = 0; k < 6; k++) begin
      pp = k + 1;
      for (int n = 0; n < 500; n++) begin
        if (n % 50 == 0) begin
          bus.thresh = 5'($urandom_range(0, DEPTH));
          bus.irq_en = $urandom_range(0, 3) != 0;
        end
        step($urandom_range(0, 199) != 0, 1'($urandom_range(0, 1)), 8'($urandom),
             $urandom_range(0, 7) < pp, $urandom_range(0, 99) == 0, $urandom_range(0, 31) == 0);
      end
    end
    step(1, 0, 8'h00, 0, 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
